// File: rtl/timer_ms_multi_pkg.sv
// Shared types for the multi-channel millisecond timer: channel state and
// count-direction encodings, plus a prescaler width helper.
package timer_ms_multi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic {
    MODE_UP   = 1'b0,
    MODE_DOWN = 1'b1
  } mode_e;

  // Prescaler counter width; a 1-bit floor keeps degenerate parameters legal.
  function automatic int ps_width(input int clk_per_ms);
    return (clk_per_ms > 1) ? $clog2(clk_per_ms) : 1;
  endfunction

endpackage : timer_ms_multi_pkg

// File: rtl/timer_ms_multi_if.sv
// Control/status bundle between the game FSM (master) and the timer (slave).
// Per-channel fields are packed; channel i owns bit i or slice [i*CNT_W +: CNT_W].
interface timer_ms_multi_if #(
  parameter int NCH   = 2,
  parameter int CNT_W = 21
);

  logic [NCH-1:0]       Start;
  logic [NCH-1:0]       Clr;
  logic [NCH-1:0]       Load;
  logic [NCH-1:0]       Mode;
  logic [NCH*CNT_W-1:0] LoadVal;
  logic [NCH*CNT_W-1:0] T;
  logic [NCH-1:0]       Done;
  logic                 Tick;

  modport master (
    output Start, Clr, Load, Mode, LoadVal,
    input  T, Done, Tick
  );

  modport slave (
    input  Start, Clr, Load, Mode, LoadVal,
    output T, Done, Tick
  );

endinterface : timer_ms_multi_if

// File: rtl/timer_ms_multi_channel.sv
// One timer channel: IDLE/RUN/HOLD/DONE state machine, saturating up/down
// ms counter and a direction register that is only open in IDLE/HOLD.
module timer_ms_multi_channel
  import timer_ms_multi_pkg::*;
#(
  parameter int CNT_W = 21
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             tick,
  input  logic             start,
  input  logic             clr,
  input  logic             load,
  input  logic             mode,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  mode_e            mode_q,  mode_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;

    // Direction can only change while the channel is not counting.
    if (state_q == ST_IDLE || state_q == ST_HOLD) begin
      mode_d = mode_e'(mode);
    end

    if (clr) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (load) begin
      state_d = ST_HOLD;
      cnt_d   = load_val;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (start) state_d = ST_RUN;
        end
        ST_HOLD: begin
          if (start) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!start) begin
            state_d = ST_HOLD;
          end else if (tick) begin
            if (mode_q == MODE_UP) begin
              // Done rises on the edge that writes the saturated value.
              if (cnt_q == CNT_MAX) begin
                state_d = ST_DONE;
              end else begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_MAX - CNT_ONE) state_d = ST_DONE;
              end
            end else begin
              if (cnt_q == '0) begin
                state_d = ST_DONE;
              end else begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) state_d = ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_UP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = (state_q == ST_DONE);

endmodule : timer_ms_multi_channel

// File: rtl/timer_ms_multi.sv
// NCH independent millisecond timers sharing one free-running prescaler whose
// registered Tick advances every running channel once per ms.
module timer_ms_multi
  import timer_ms_multi_pkg::*;
#(
  parameter int CLK_PER_MS = 50000,
  parameter int CNT_W      = 21,
  parameter int NCH        = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  timer_ms_multi_if.slave   bus
);

  localparam int              PS_W    = ps_width(CLK_PER_MS);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_PER_MS - 1);
  localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

  logic [PS_W-1:0] presc_q, presc_d;
  logic            tick_q,  tick_d;

  always_comb begin
    presc_d = presc_q + PS_ONE;
    tick_d  = 1'b0;
    if (presc_q == PS_LAST) begin
      presc_d = '0;
      tick_d  = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.Tick = tick_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    timer_ms_multi_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .Clk      (Clk),
      .Rst      (Rst),
      .tick     (tick_q),
      .start    (bus.Start[i]),
      .clr      (bus.Clr[i]),
      .load     (bus.Load[i]),
      .mode     (bus.Mode[i]),
      .load_val (bus.LoadVal[i*CNT_W +: CNT_W]),
      .cnt      (bus.T[i*CNT_W +: CNT_W]),
      .done     (bus.Done[i])
    );
  end

endmodule : timer_ms_multi

// File: tb/tb_timer_ms_multi.sv
// Directed bench for timer_ms_multi with CLK_PER_MS=4, CNT_W=4, NCH=2.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_timer_ms_multi;

  localparam int CW = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  timer_ms_multi_if #(.NCH(2), .CNT_W(CW)) bus ();

  timer_ms_multi #(
    .CLK_PER_MS (4),
    .CNT_W      (CW),
    .NCH        (2)
  ) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] t_of(input int ch);
    return 32'(bus.T[ch*CW +: CW]);
  endfunction

  task automatic set_val(input int ch, input logic [CW-1:0] v);
    bus.LoadVal[ch*CW +: CW] = v;
  endtask

  // Leaves the bench on the falling edge where Tick is high.
  task automatic wait_tick_high();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.Tick) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) check("tick_timeout", 32'(found), 32'd1);
  endtask

  // Lets one Tick be applied, returning on the falling edge after it.
  task automatic next_tick();
    wait_tick_high();
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    bus.Start = '0; bus.Clr = '0; bus.Load = '0; bus.Mode = '0; bus.LoadVal = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_t0", t_of(0), 0);
    check("rst_t1", t_of(1), 0);
    check("rst_done", 32'(bus.Done), 0);
    check("rst_tick", 32'(bus.Tick), 0);
    rst = 1'b0;

    // 1. ch0 up 5, pause across 3, resume 2
    bus.Start[0] = 1'b1;
    @(negedge clk);
    repeat (5) next_tick();
    check("t1_up5", t_of(0), 5);
    bus.Start[0] = 1'b0;
    @(negedge clk);
    repeat (3) next_tick();
    check("t1_hold", t_of(0), 5);
    bus.Start[0] = 1'b1;
    @(negedge clk);
    repeat (2) next_tick();
    check("t1_up7", t_of(0), 7);
    check("t1_ch1_idle", t_of(1), 0);
    check("t1_done0", 32'(bus.Done[0]), 0);
    bus.Start[0] = 1'b0;
    @(negedge clk);

    // 2. ch1 down from 3
    bus.Load[1] = 1'b1; bus.Mode[1] = 1'b1; set_val(1, 4'd3);
    @(negedge clk);
    bus.Load[1] = 1'b0;
    check("t2_load", t_of(1), 3);
    bus.Start[1] = 1'b1;
    @(negedge clk);
    check("t2_start_no_count", t_of(1), 3);
    next_tick(); check("t2_dn2", t_of(1), 2);
    next_tick(); check("t2_dn1", t_of(1), 1);
    check("t2_done_lo", 32'(bus.Done[1]), 0);
    next_tick(); check("t2_dn0", t_of(1), 0);
    check("t2_done_hi", 32'(bus.Done[1]), 1);
    repeat (2) next_tick();
    check("t2_stay0", t_of(1), 0);
    check("t2_stay_done", 32'(bus.Done[1]), 1);
    check("t2_ch0_held", t_of(0), 7);

    // 3. ch0 up to saturation, then clear
    bus.Clr[0] = 1'b1;
    @(negedge clk);
    bus.Clr[0] = 1'b0;
    check("t3_clr_t", t_of(0), 0);
    bus.Start[0] = 1'b1;
    @(negedge clk);
    repeat (14) next_tick();
    check("t3_t14", t_of(0), 14);
    check("t3_done_lo", 32'(bus.Done[0]), 0);
    next_tick();
    check("t3_t15", t_of(0), 15);
    check("t3_done_hi", 32'(bus.Done[0]), 1);
    next_tick();
    check("t3_no_wrap", t_of(0), 15);
    bus.Clr[0] = 1'b1; bus.Start[0] = 1'b0;
    @(negedge clk);
    bus.Clr[0] = 1'b0;
    check("t3_clr_t0", t_of(0), 0);
    check("t3_clr_done", 32'(bus.Done[0]), 0);

    // 4. Clr beats Load on a Tick; Load alone discards its Tick
    bus.Start[0] = 1'b1;
    @(negedge clk);
    wait_tick_high();
    bus.Clr[0] = 1'b1; bus.Load[0] = 1'b1; set_val(0, 4'd9); bus.Start[0] = 1'b0;
    @(negedge clk);
    bus.Clr[0] = 1'b0; bus.Load[0] = 1'b0;
    check("t4_clr_wins", t_of(0), 0);
    bus.Start[0] = 1'b1;
    @(negedge clk);
    wait_tick_high();
    bus.Load[0] = 1'b1;
    @(negedge clk);
    bus.Load[0] = 1'b0; bus.Start[0] = 1'b0;
    check("t4_load9", t_of(0), 9);
    next_tick();
    check("t4_hold9", t_of(0), 9);
    check("t4_done0", 32'(bus.Done[0]), 0);

    // 5. down from 0 finishes without wrapping; Mode ignored while running
    bus.Start[1] = 1'b0; bus.Load[1] = 1'b1; set_val(1, 4'd0); bus.Mode[1] = 1'b1;
    @(negedge clk);
    bus.Load[1] = 1'b0;
    check("t5_load_done_clr", 32'(bus.Done[1]), 0);
    bus.Start[1] = 1'b1;
    @(negedge clk);
    next_tick();
    check("t5_zero_t", t_of(1), 0);
    check("t5_zero_done", 32'(bus.Done[1]), 1);
    bus.Start[1] = 1'b0; bus.Load[1] = 1'b1; set_val(1, 4'd5);
    @(negedge clk);
    bus.Load[1] = 1'b0; bus.Start[1] = 1'b1;
    @(negedge clk);
    bus.Mode[1] = 1'b0;
    next_tick(); check("t5_mode_ign1", t_of(1), 4);
    next_tick(); check("t5_mode_ign2", t_of(1), 3);

    // 6. async reset mid-cycle, then first Tick timing
    bus.Start = '0; bus.Load = 2'b11; set_val(0, 4'd6); set_val(1, 4'd2);
    @(negedge clk);
    bus.Load = '0;
    check("t6_pre_t0", t_of(0), 6);
    check("t6_pre_t1", t_of(1), 2);
    wait_tick_high();
    #5 rst = 1'b1;
    #1;
    check("t6_async_t0", t_of(0), 0);
    check("t6_async_t1", t_of(1), 0);
    check("t6_async_tick", 32'(bus.Tick), 0);
    check("t6_async_done", 32'(bus.Done), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check($sformatf("t6_no_tick_%0d", i), 32'(bus.Tick), 0);
    end
    @(negedge clk);
    check("t6_first_tick", 32'(bus.Tick), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_timer_ms_multi
